acc_register_ctrl: RTL and testbench

Accumulation register and controller directly downstream of the signed `adder` building block. It captures the adder's sum each accepted cycle and feeds the running value back to the adder's `b` input. It counts a programmed number of terms and presents the final sum on a valid/ready output port. Together with `adder` it forms the team's reusable accumulate datapath, used in MAC and reduction stages.

---
 rtl/acc_register_ctrl.sv | 136 +++++++++++++
 tb/tb_acc_register_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/acc_register_ctrl.sv
// acc_register_ctrl: accumulation register and controller placed downstream of
// the signed adder. Captures the adder sum on each accepted term, feeds the
// running value back through acc_out, counts num_terms accepted terms and
// presents the final sum on a valid/ready output port.
//
// Build option: define ACC_SATURATE_EN to clamp the accumulator on overflow;
// when undefined, overflowing sums wrap (two's complement). The sticky ovf
// flag behaves identically in both builds.
module acc_register_ctrl #(
  parameter int IN_WIDTH  = 17,
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [CNT_WIDTH-1:0]        num_terms,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic signed [ACC_WIDTH-1:0] acc_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] out_data,
  output logic                        ovf,
  output logic                        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bits that must all match for in_data to fit in ACC_WIDTH signed bits.
  localparam int TOP_W = IN_WIDTH - ACC_WIDTH + 1;

  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  state_e                      state_q;
  logic [CNT_WIDTH-1:0]        remaining_q;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic                        ovf_q;
  logic                        in_ready_q;
  logic                        out_valid_q;
  logic                        busy_q;

  logic [TOP_W-1:0]            top_bits;
  logic                        in_ovf;
  logic signed [ACC_WIDTH-1:0] acc_d;

  assign top_bits = in_data[IN_WIDTH-1:ACC_WIDTH-1];

  // Narrow the adder sum to accumulator width and flag sums that do not fit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    in_ovf = !((&top_bits) || !(|top_bits));
    acc_d  = in_data[ACC_WIDTH-1:0];
`ifdef ACC_SATURATE_EN
    if (in_ovf) begin
      acc_d = in_data[IN_WIDTH-1] ? ACC_MIN : ACC_MAX;
    end
`else
    // Overflow keeps the wrapped low bits already selected above.
`endif
  end

  // Control FSM, term counter, accumulator and registered handshake outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset is synchronous and wins over everything.
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            remaining_q <= num_terms;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b1;
            if (num_terms != '0) begin
              state_q    <= ACCUM;
              in_ready_q <= 1'b1;
            end else begin
              // Zero terms: result of 0, out_valid raised one cycle later.
              state_q    <= DONE;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_q       <= acc_d;
            remaining_q <= remaining_q - CNT_WIDTH'(1);
            if (in_ovf) begin
              ovf_q <= 1'b1;
            end
            if (remaining_q == CNT_WIDTH'(1)) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_valid_q && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign acc_out   = acc_q;
  assign out_data  = acc_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_acc_register_ctrl.sv
// tb_acc_register_ctrl: self-checking bench for acc_register_ctrl. The adder is
// modelled as in_data = x + acc_out; expected sums come from integer arithmetic
// over the list of terms.
module tb_acc_register_ctrl;

  localparam int IW = 17;
  localparam int AW = 16;
  localparam int CW = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [CW-1:0]        num_terms;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [IW-1:0] in_data;
  logic signed [AW-1:0] acc_out;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [AW-1:0] out_data;
  logic                 ovf;
  logic                 busy;
  logic signed [AW-1:0] x;

  int total = 0;
  int bad   = 0;

  int xq[$];      // terms of the current run
  int vq[$];      // explicit in_valid pattern (gap mode 2)
  int stepq[$];   // expected acc_out after each accepted term
  bit exp_ovf;

  always #5 clk = ~clk;

  // Adder in front of the accumulator.
  assign in_data = {x[AW-1], x} + {acc_out[AW-1], acc_out};

  acc_register_ctrl #(.IN_WIDTH(IW), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_terms (num_terms),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .acc_out   (acc_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ovf       (ovf),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected running sums for the terms in xq.
  task automatic model_run();
    int acc = 0;
    int s;
    stepq.delete();
    exp_ovf = 1'b0;
    foreach (xq[i]) begin
      s = acc + xq[i];
      if (s > 32767 || s < -32768) begin
        exp_ovf = 1'b1;
`ifdef ACC_SATURATE_EN
        acc = (s > 32767) ? 32767 : -32768;
`else
        acc = ((s + 98304) % 65536) - 32768;
`endif
      end else begin
        acc = s;
      end
      stepq.push_back(acc);
    end
  endtask

  // One full accumulation over xq. gap_mode: 0 in_valid always high,
  // 1 random gaps, 2 pattern from vq. Stalls out_ready for 'stall' cycles,
  // optionally pulsing start while the result is pending.
  task automatic run(input string name, input int gap_mode, input int stall,
                     input bit poke);
    int n = xq.size();
    int accepted = 0;
    int cyc = 0;
    int vi = 0;
    bit v;
    model_run();
    start     = 1'b1;
    num_terms = CW'(n);
    tick();
    start     = 1'b0;
    check({name, "_busy_start"}, busy, 1);
    check({name, "_in_ready_start"}, in_ready, n != 0);
    check({name, "_acc_clear"}, acc_out, 0);
    check({name, "_ovf_clear"}, ovf, 0);
    check({name, "_out_valid_start"}, out_valid, 0);
    while (accepted < n && cyc < 200) begin
      if (gap_mode == 0)      v = 1'b1;
      else if (gap_mode == 1) v = 1'($urandom_range(0, 1));
      else                    v = (vi < vq.size()) ? vq[vi] != 0 : 1'b1;
      vi++;
      in_valid = v;
      x = AW'(xq[accepted]);
      tick();
      cyc++;
      if (v) accepted++;
      check({name, "_acc_step"}, acc_out, (accepted == 0) ? 0 : stepq[accepted-1]);
      check({name, "_out_valid_timing"}, out_valid, accepted == n);
    end
    in_valid = 1'b0;
    check({name, "_accept_count"}, accepted, n);
    if (n == 0) begin
      tick();
      check({name, "_in_ready_zero"}, in_ready, 0);
    end
    check({name, "_out_valid"}, out_valid, 1);
    check({name, "_out_data"}, out_data, (n == 0) ? 0 : stepq[n-1]);
    check({name, "_ovf"}, ovf, exp_ovf);
    for (int i = 0; i < stall; i++) begin
      start     = poke && (i == 1);
      num_terms = CW'($urandom_range(1, 5));
      tick();
      start = 1'b0;
      check({name, "_stall_valid"}, out_valid, 1);
      check({name, "_stall_data"}, out_data, (n == 0) ? 0 : stepq[n-1]);
      check({name, "_stall_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_handshake_valid"}, out_valid, 0);
    check({name, "_handshake_busy"}, busy, 0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    num_terms = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;

    // Reset held two cycles.
    tick();
    tick();
    rst = 1'b0;
    check("reset_acc", acc_out, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_ovf", ovf, 0);
    check("reset_out_data", out_data, 0);

    // Three terms, in_valid held high.
    xq = '{5, 7, -15};
    run("basic", 0, 0, 1'b0);

    // Same terms, gapped in_valid, output stalled with a start poke in DONE.
    vq = '{1, 0, 0, 1, 1};
    run("gapped", 2, 4, 1'b1);

    // Overflow on the second term.
    xq = '{32767, 1};
    run("overflow", 0, 0, 1'b0);

    // Zero terms.
    xq.delete();
    run("zero", 0, 1, 1'b0);

    // Reset after two of five terms, then a fresh one-term run.
    start     = 1'b1;
    num_terms = CW'(5);
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    x        = 16'sd100;
    tick();
    tick();
    check("midrst_acc_before", acc_out, 200);
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    check("midrst_acc", acc_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_ovf", ovf, 0);
    xq = '{9};
    run("after_rst", 0, 0, 1'b0);

    // Randomized runs, mixing small and full-range terms.
    for (int r = 0; r < 12; r++) begin
      int n = $urandom_range(1, 8);
      xq.delete();
      for (int i = 0; i < n; i++) begin
        if (r % 2 == 0) xq.push_back($urandom_range(0, 65535) - 32768);
        else            xq.push_back($urandom_range(0, 200) - 100);
      end
      run("random", 1, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
